// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts ecall/ebreak/mret/interrupt, writes mepc/mstatus/mcause, then redirects.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets when mtvec[1:0] == 2'b01.
module trap_ctrl #(
    parameter logic [31:0] INT_CAUSE    = 32'h8000_0007,
    parameter logic [31:0] ECALL_CAUSE  = 32'd11,
    parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        int_flag_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        div_busy_i,
    input  logic        global_int_en_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_flag_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MSTATUS,
        W_MCAUSE,
        W_MRET,
        JUMP
    } state_t;

    localparam logic [31:0] ADDR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] ADDR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] ADDR_MCAUSE  = 32'h0000_0342;

    state_t      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic        is_int_q, is_int_d;
    logic        is_ret_q, is_ret_d;

    logic        exc_req;
    logic        irq_req;
    logic        any_req;
    logic [31:0] mtvec_base;
    logic [31:0] trap_target;

    assign exc_req    = ecall_i | ebreak_i;
    assign irq_req    = int_flag_i & global_int_en_i & ~div_busy_i;
    assign any_req    = exc_req | mret_i | irq_req;
    assign mtvec_base = {csr_mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // Only interrupts are vectored; synchronous exceptions always land on the base address.
    assign trap_target = (csr_mtvec_i[1:0] == 2'b01 && is_int_q)
                         ? mtvec_base + {INT_CAUSE[29:0], 2'b00}
                         : mtvec_base;
`else
    logic unused_mode_bits;
    assign unused_mode_bits = &{1'b0, csr_mtvec_i[1:0], is_int_q};
    assign trap_target      = mtvec_base;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cause_q  <= '0;
            epc_q    <= '0;
            is_int_q <= 1'b0;
            is_ret_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            is_int_q <= is_int_d;
            is_ret_q <= is_ret_d;
        end
    end

    // Acceptance priority in IDLE: exceptions, then mret, then a qualified interrupt.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        is_int_d = is_int_q;
        is_ret_d = is_ret_q;
        case (state_q)
            IDLE: begin
                if (exc_req) begin
                    state_d  = W_MEPC;
                    cause_d  = ecall_i ? ECALL_CAUSE : EBREAK_CAUSE;
                    epc_d    = inst_addr_i;
                    is_int_d = 1'b0;
                    is_ret_d = 1'b0;
                end else if (mret_i) begin
                    state_d  = W_MRET;
                    is_int_d = 1'b0;
                    is_ret_d = 1'b1;
                end else if (irq_req) begin
                    state_d  = W_MEPC;
                    cause_d  = INT_CAUSE;
                    epc_d    = jump_flag_i ? jump_addr_i : inst_addr_i;
                    is_int_d = 1'b1;
                    is_ret_d = 1'b0;
                end
            end
            W_MEPC:    state_d = W_MSTATUS;
            W_MSTATUS: state_d = W_MCAUSE;
            W_MCAUSE:  state_d = JUMP;
            W_MRET:    state_d = JUMP;
            JUMP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs decode the registered state; the IDLE accept into hold is the only input-to-output path.
    always_comb begin
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        hold_flag_o  = (state_q != IDLE) | (rst & any_req);
        case (state_q)
            W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = epc_q;
            end
            W_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                               1'b0, csr_mstatus_i[2:0]};
            end
            W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            W_MRET: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                               csr_mstatus_i[7], csr_mstatus_i[2:0]};
            end
            JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = is_ret_q ? csr_mepc_i : trap_target;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized traffic against a queue-based model.
// Honours TRAP_VECTORED_EN the same way the design does.
module tb_trap_ctrl;

    localparam logic [31:0] INT_CAUSE = 32'h8000_0007;

    logic        clk = 1'b0;
    logic        rst;
    logic        ecall, ebreak, mret, int_flag, jump_flag, div_busy, gie;
    logic [31:0] inst_addr, jump_addr, mtvec, mepc, mstatus;
    logic        csr_we, hold_flag, int_assert;
    logic [31:0] csr_waddr, csr_wdata, int_addr;

    int checks = 0;
    int errors = 0;
    int jumpCount = 0;
    logic [31:0] lastJumpAddr = '0;

    // Model: a list of pending output actions plus the details captured when the trap was taken.
    int          plan[$];
    logic [31:0] mEpc, mCause;
    bit          mIsInt;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk(clk), .rst(rst),
        .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret), .int_flag_i(int_flag),
        .inst_addr_i(inst_addr), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .div_busy_i(div_busy), .global_int_en_i(gie),
        .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus),
        .csr_we_o(csr_we), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
        .hold_flag_o(hold_flag), .int_assert_o(int_assert), .int_addr_o(int_addr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] handlerAddr(input bit isInt);
        logic [31:0] base;
        base = mtvec & ~32'd3;
`ifdef TRAP_VECTORED_EN
        if (isInt && (mtvec % 4) == 1)
            base = base + 4 * (INT_CAUSE & 32'h7FFF_FFFF);
`endif
        return base;
    endfunction

    task automatic clearInputs();
        ecall = 0; ebreak = 0; mret = 0; int_flag = 0; jump_flag = 0; div_busy = 0; gie = 0;
        inst_addr = '0; jump_addr = '0; mtvec = '0; mepc = '0; mstatus = '0;
    endtask

    task automatic applyStimulus();
        rst       = ($urandom_range(0, 49) != 0);
        ecall     = ($urandom_range(0, 15) == 0);
        ebreak    = ($urandom_range(0, 15) == 0);
        mret      = ($urandom_range(0, 15) == 0);
        int_flag  = $urandom_range(0, 1);
        gie       = $urandom_range(0, 1);
        div_busy  = ($urandom_range(0, 3) == 0);
        jump_flag = $urandom_range(0, 1);
        inst_addr = $urandom;
        jump_addr = $urandom;
        mtvec     = $urandom;
        mepc      = $urandom;
        mstatus   = $urandom;
    endtask

    // Checks one cycle at the falling edge, then leaves the caller just after the next rising edge.
    task automatic runCycle();
        logic        eHold, eWe, eAssert;
        logic [31:0] eAddr, eData, eTarget;
        int          step;
        @(negedge clk);
        eHold = 0; eWe = 0; eAssert = 0; eAddr = '0; eData = '0; eTarget = '0;
        if (!rst) begin
            plan.delete();
        end else if (plan.size() > 0) begin
            step  = plan.pop_front();
            eHold = 1;
            case (step)
                1: begin eWe = 1; eAddr = 32'h341; eData = mEpc; end
                2: begin eWe = 1; eAddr = 32'h300;
                         eData = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0); end
                3: begin eWe = 1; eAddr = 32'h342; eData = mCause; end
                4: begin eAssert = 1; eTarget = handlerAddr(mIsInt); end
                5: begin eWe = 1; eAddr = 32'h300;
                         eData = (mstatus & ~32'h88) | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0); end
                default: begin eAssert = 1; eTarget = mepc; end
            endcase
        end else if (ecall || ebreak) begin
            eHold = 1; mEpc = inst_addr; mCause = ecall ? 32'd11 : 32'd3; mIsInt = 0;
            plan = '{1, 2, 3, 4};
        end else if (mret) begin
            eHold = 1;
            plan = '{5, 6};
        end else if (int_flag && gie && !div_busy) begin
            eHold = 1; mEpc = jump_flag ? jump_addr : inst_addr; mCause = INT_CAUSE; mIsInt = 1;
            plan = '{1, 2, 3, 4};
        end
        checkOutput("hold", {31'd0, hold_flag}, {31'd0, eHold});
        checkOutput("csr_we", {31'd0, csr_we}, {31'd0, eWe});
        checkOutput("csr_waddr", csr_waddr, eAddr);
        checkOutput("csr_wdata", csr_wdata, eData);
        checkOutput("int_assert", {31'd0, int_assert}, {31'd0, eAssert});
        checkOutput("int_addr", int_addr, eTarget);
        if (int_assert === 1'b1) begin
            jumpCount++;
            lastJumpAddr = int_addr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) runCycle();
    endtask

    initial begin
        int jumpsBefore;
        rst = 0;
        clearInputs();
        @(posedge clk);
        #1;
        idleCycles(2);
        rst = 1;
        idleCycles(1);

        $display("[TB] ecall entry");
        inst_addr = 32'h100; mtvec = 32'h200; mstatus = 32'h8; ecall = 1;
        runCycle();
        ecall = 0;
        idleCycles(5);
        checkOutput("ecall_target", lastJumpAddr, 32'h200);

        $display("[TB] mret return");
        mstatus = 32'h80; mepc = 32'h104; mret = 1;
        runCycle();
        mret = 0;
        idleCycles(3);
        checkOutput("mret_target", lastJumpAddr, 32'h104);

        $display("[TB] interrupt with redirect in flight");
        mstatus = 32'h8; int_flag = 1; gie = 1; jump_flag = 1; jump_addr = 32'h300; inst_addr = 32'h120;
        runCycle();
        gie = 0;
        idleCycles(8);
        int_flag = 0; jump_flag = 0;

        $display("[TB] ecall beats interrupt, busy divider blocks interrupt");
        ecall = 1; int_flag = 1; gie = 1; inst_addr = 32'h140;
        runCycle();
        ecall = 0; int_flag = 0;
        idleCycles(5);
        int_flag = 1; div_busy = 1;
        idleCycles(3);
        div_busy = 0;
        runCycle();
        int_flag = 0;
        idleCycles(5);

        $display("[TB] reset mid-sequence");
        jumpsBefore = jumpCount;
        ecall = 1; inst_addr = 32'h180;
        runCycle();
        ecall = 0;
        runCycle();
        rst = 0;
        runCycle();
        rst = 1;
        idleCycles(6);
        checkOutput("reset_no_jump", jumpCount - jumpsBefore, 0);

`ifdef TRAP_VECTORED_EN
        $display("[TB] vectored mode");
        mtvec = 32'h201; mstatus = 32'h8; int_flag = 1; gie = 1;
        runCycle();
        int_flag = 0; gie = 0;
        idleCycles(5);
        checkOutput("vector_irq_target", lastJumpAddr, 32'h21C);
        ecall = 1;
        runCycle();
        ecall = 0;
        idleCycles(5);
        checkOutput("vector_ecall_target", lastJumpAddr, 32'h200);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            runCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
